// File: rtl/comparator_pkg.sv
// Shared types for the serial comparator: FSM state encoding and result-flag layout.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_LT = 0;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_GT = 2;
  localparam int unsigned FLAG_W  = 3;

  typedef logic [FLAG_W-1:0] flags_t;

  localparam flags_t RES_LT = flags_t'(1 << FLAG_LT);
  localparam flags_t RES_EQ = flags_t'(1 << FLAG_EQ);
  localparam flags_t RES_GT = flags_t'(1 << FLAG_GT);

endpackage

// File: rtl/comparator_serial_if.sv
// Request/result bundle for comparator_serial; master issues operands, slave returns flags.
interface comparator_serial_if #(
    parameter int unsigned N = 16
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic         smaller;
    logic         equal;
    logic         greater;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, smaller, equal, greater
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, smaller, equal, greater
    );
endinterface

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one K-bit chunk.
module comparator_chunk #(
    parameter int unsigned K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         lt,
    output logic         eq
);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

// File: rtl/comparator_serial.sv
// Serial magnitude comparator: examines K bits per cycle, MSB chunk first,
// stopping at the first differing chunk.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned K = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_serial_if.slave    bus
);
    localparam int unsigned NCHUNK = N / K;
    localparam int unsigned CW     = $clog2(NCHUNK) + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t        state, state_next;
    logic [N-1:0]  op_a, op_b;
    logic [CW-1:0] cnt;
    flags_t        flags, flags_next;
    logic          capture, shift;
    logic          chunk_lt, chunk_eq;
    logic [N-1:0]  sign_mask;

    // Flipping the MSB of both operands maps two's-complement order onto unsigned order.
    always_comb begin
        sign_mask        = '0;
        sign_mask[N-1]   = bus.is_signed;
    end

    comparator_chunk #(.K(K)) u_chunk (
        .a  (op_a[N-1 -: K]),
        .b  (op_b[N-1 -: K]),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    always_comb begin
        state_next = state;
        flags_next = flags;
        capture    = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    capture    = 1'b1;
                    state_next = CMP;
                end else begin
                    state_next = IDLE;
                end
            end
            CMP: begin
                if (!chunk_eq) begin
                    flags_next = chunk_lt ? RES_LT : RES_GT;
                    state_next = DONE;
                end else if (cnt == LAST) begin
                    flags_next = RES_EQ;
                    state_next = DONE;
                end else begin
                    shift = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            flags <= '0;
            op_a  <= '0;
            op_b  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            flags <= flags_next;
            if (capture) begin
                op_a <= bus.a ^ sign_mask;
                op_b <= bus.b ^ sign_mask;
                cnt  <= '0;
            end else if (shift) begin
                op_a <= op_a << K;
                op_b <= op_b << K;
                cnt  <= cnt + CW'(1);
            end
        end
    end

    assign bus.busy    = (state == CMP);
    assign bus.done    = (state == DONE);
    assign bus.smaller = flags[FLAG_LT];
    assign bus.equal   = flags[FLAG_EQ];
    assign bus.greater = flags[FLAG_GT];

endmodule
